counts_readout: RTL and testbench

Readout transmitter for the coincidence detector. It periodically snapshots the detector's per-pair `Counts` array and serializes each snapshot as a framed byte stream over a valid/ready interface. It sits between the detector and the host link (UART or FIFO bridge), and consumes exactly the `Counts` bus the detector produces.

---
 rtl/detector_pkg.sv | 19 +
 rtl/window_timer.sv | 28 ++
 rtl/counts_readout.sv | 110 +++++++++++
 tb/tb_counts_readout.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/detector_pkg.sv
// Shared definitions for the coincidence detector and its readout path.
// Holds the frame header constant, readout FSM states and the pair-count helper.
package detector_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        SEQ  = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4
    } rd_state_t;

    function automatic int npairs(input int nchan);
        return nchan * (nchan - 1) / 2;
    endfunction

endpackage

// File: rtl/window_timer.sv
// Snapshot window timer: counts 0..WINDOW-1 while enabled, holds otherwise.
// Tc is combinational from the registered count, asserted only while Enable=1.
module window_timer #(
    parameter int WINDOW = 1000
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Enable,
    output logic Tc
);

    localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic [TW-1:0] cnt;
    logic          at_end;

    assign at_end = (cnt == TW'(WINDOW - 1));
    assign Tc     = Enable && at_end;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt <= '0;
        end else if (Enable) begin
            cnt <= at_end ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/counts_readout.sv
// Snapshots detector pair counts each window and streams them as a framed byte sequence.
// Latency: header valid one cycle after TC; Tx_data holds while valid and not ready.
module counts_readout
    import detector_pkg::*;
#(
    parameter int NCHAN  = 4,
    parameter int NBITS  = 4,
    parameter int NPAIRS = npairs(NCHAN),
    parameter int WINDOW = 1000
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          Enable,
    input  logic [NPAIRS-1:0][NBITS-1:0]  Counts,
    output logic [7:0]                    Tx_data,
    output logic                          Tx_valid,
    input  logic                          Tx_ready,
    output logic                          Overrun,
    output logic [7:0]                    Missed
);

    localparam int              IW   = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
    localparam logic [IW-1:0]   LAST = IW'(NPAIRS - 1);

    rd_state_t                    state;
    logic [IW-1:0]                idx;
    logic [IW-1:0]                idx_nxt;
    logic [NPAIRS-1:0][NBITS-1:0] shadow;
    logic [7:0]                   seq;
    logic [7:0]                   csum;
    logic                         tc;
    logic                         accept;

    window_timer #(
        .WINDOW (WINDOW)
    ) u_timer (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .Enable (Enable),
        .Tc     (tc)
    );

    assign accept  = Tx_valid && Tx_ready;
    assign idx_nxt = idx + 1'b1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            shadow   <= '0;
            seq      <= '0;
            csum     <= '0;
            Tx_data  <= '0;
            Tx_valid <= 1'b0;
            Overrun  <= 1'b0;
            Missed   <= '0;
        end else begin
            // A TC that lands while any frame byte is outstanding (including the
            // checksum being accepted on this same edge) is dropped, not queued.
            if (tc) begin
                if (state == IDLE) begin
                    shadow   <= Counts;
                    state    <= HDR;
                    Tx_valid <= 1'b1;
                    Tx_data  <= FRAME_HDR;
                    csum     <= '0;
                end else begin
                    Overrun <= 1'b1;
                    if (Missed != 8'hFF) begin
                        Missed <= Missed + 8'd1;
                    end
                end
            end

            if (accept) begin
                csum <= csum ^ Tx_data;
                case (state)
                    HDR: begin
                        Tx_data <= seq;
                        state   <= SEQ;
                    end
                    SEQ: begin
                        Tx_data <= 8'(shadow[0]);
                        idx     <= '0;
                        state   <= DATA;
                    end
                    DATA: begin
                        if (idx == LAST) begin
                            Tx_data <= csum ^ Tx_data;
                            state   <= CSUM;
                        end else begin
                            idx     <= idx_nxt;
                            Tx_data <= 8'(shadow[idx_nxt]);
                        end
                    end
                    CSUM: begin
                        Tx_valid <= 1'b0;
                        state    <= IDLE;
                        seq      <= seq + 8'd1;
                    end
                    default: begin
                        Tx_valid <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counts_readout.sv
// Bench for counts_readout: frame-level reference model (expected byte queue built
// at each snapshot) compared cycle by cycle, plus directed checks on key scenarios.
module tb_counts_readout;

    localparam int NCHAN  = 4;
    localparam int NBITS  = 4;
    localparam int NPAIRS = 6;
    localparam int WINDOW = 16;

    logic                         Clk = 1'b0;
    logic                         Rst_n = 1'b0;
    logic                         Enable = 1'b0;
    logic                         Tx_ready = 1'b0;
    logic [NPAIRS-1:0][NBITS-1:0] Counts = '0;
    logic [7:0]                   Tx_data;
    logic                         Tx_valid;
    logic                         Overrun;
    logic [7:0]                   Missed;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] seq_log[$];
    int         en_cyc = 0;
    int         pos = 0;
    logic [7:0] m_seq = '0;
    logic [7:0] m_missed = '0;
    logic       m_ovr = 1'b0;

    counts_readout #(
        .NCHAN  (NCHAN),
        .NBITS  (NBITS),
        .WINDOW (WINDOW)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Enable   (Enable),
        .Counts   (Counts),
        .Tx_data  (Tx_data),
        .Tx_valid (Tx_valid),
        .Tx_ready (Tx_ready),
        .Overrun  (Overrun),
        .Missed   (Missed)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        got_q.delete();
        seq_log.delete();
        en_cyc   = 0;
        pos      = 0;
        m_seq    = '0;
        m_missed = '0;
        m_ovr    = 1'b0;
    endtask

    // Whole frame as the host would see it: header, seq, counts, XOR of all before.
    task automatic push_frame(input logic [NPAIRS-1:0][NBITS-1:0] c);
        logic [7:0] x;
        x = 8'hA5 ^ m_seq;
        exp_q.push_back(8'hA5);
        exp_q.push_back(m_seq);
        for (int i = 0; i < NPAIRS; i++) begin
            exp_q.push_back(8'(c[i]));
            x ^= 8'(c[i]);
        end
        exp_q.push_back(x);
    endtask

    // Called just after a falling edge with inputs already set; returns at the next falling edge.
    task automatic tick();
        logic                         acc;
        logic                         tc;
        logic                         busy;
        logic                         hold;
        logic [7:0]                   pre_data;
        logic [7:0]                   b;
        logic [NPAIRS-1:0][NBITS-1:0] pre_counts;
        acc        = Tx_valid && Tx_ready;
        tc         = Enable && ((en_cyc % WINDOW) == WINDOW - 1);
        busy       = (exp_q.size() != 0);
        hold       = Tx_valid && !Tx_ready;
        pre_data   = Tx_data;
        pre_counts = Counts;
        @(posedge Clk);
        if (Enable) en_cyc++;
        if (acc) begin
            chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("byte", pre_data, b);
                got_q.push_back(pre_data);
                if (pos == 1) seq_log.push_back(pre_data);
                if (exp_q.size() == 0) begin
                    pos = 0;
                    m_seq++;
                end else begin
                    pos++;
                end
            end
        end
        if (tc) begin
            if (busy) begin
                m_ovr = 1'b1;
                if (m_missed != 8'hFF) m_missed++;
            end else begin
                push_frame(pre_counts);
            end
        end
        @(negedge Clk);
        chk("valid", Tx_valid, 32'(exp_q.size() != 0));
        chk("overrun", Overrun, m_ovr);
        chk("missed", Missed, m_missed);
        if (hold) chk("hold_stable", Tx_data, pre_data);
    endtask

    task automatic reset_dut();
        Rst_n = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0]                   basic [9];
        logic [NPAIRS-1:0][NBITS-1:0] saved;
        int                           vcount;
        int                           found;

        basic = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hA2};

        // Reset values
        @(negedge Clk);
        @(negedge Clk);
        chk("rst_valid", Tx_valid, 0);
        chk("rst_data", Tx_data, 0);
        chk("rst_overrun", Overrun, 0);
        chk("rst_missed", Missed, 0);
        Rst_n = 1'b1;
        model_reset();

        // Basic frame, two windows
        Counts   = {4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
        Enable   = 1'b1;
        Tx_ready = 1'b1;
        repeat (2 * WINDOW + 12) tick();
        chk("basic_len", got_q.size(), 18);
        if (got_q.size() >= 18) begin
            for (int i = 0; i < 9; i++) chk("basic_byte", got_q[i], basic[i]);
            chk("basic_seq2", got_q[10], 8'h01);
            chk("basic_csum2", got_q[17], 8'hA3);
        end

        // Backpressure: random ready
        got_q.delete();
        repeat (6 * WINDOW) begin
            Tx_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        Tx_ready = 1'b1;
        repeat (12) tick();
        chk("bp_frames", 32'(got_q.size() >= 9), 1);
        if (got_q.size() >= 9) begin
            chk("bp_hdr", got_q[0], 8'hA5);
            for (int i = 0; i < NPAIRS; i++) chk("bp_data", got_q[2 + i], 8'(i + 1));
        end

        // Snapshot isolation
        reset_dut();
        Enable   = 1'b1;
        Tx_ready = 1'b1;
        for (int i = 0; i < NPAIRS; i++) Counts[i] = 4'($urandom_range(0, 14));
        saved = Counts;
        for (int i = 0; i < WINDOW + 2 && exp_q.size() == 0; i++) tick();
        chk("iso_started", 32'(exp_q.size() != 0), 1);
        Counts = '1;
        repeat (12) tick();
        chk("iso_len", got_q.size(), 9);
        if (got_q.size() >= 9) begin
            for (int i = 0; i < NPAIRS; i++) chk("iso_data", got_q[2 + i], 8'(saved[i]));
        end

        // Overrun: sink stalled across two further windows
        reset_dut();
        Tx_ready = 1'b0;
        Enable   = 1'b1;
        for (int i = 0; i < NPAIRS; i++) Counts[i] = 4'($urandom);
        saved = Counts;
        repeat (WINDOW) tick();
        repeat (40) begin
            Counts[$urandom_range(0, NPAIRS - 1)] = 4'($urandom);
            tick();
        end
        chk("ovr_flag", Overrun, 1);
        chk("ovr_missed", Missed, 2);
        Tx_ready = 1'b1;
        repeat (10) tick();
        chk("ovr_len", 32'(got_q.size() >= 9), 1);
        if (got_q.size() >= 9) begin
            for (int i = 0; i < NPAIRS; i++) chk("ovr_data", got_q[2 + i], 8'(saved[i]));
        end

        // Reset mid-frame during a DATA byte
        reset_dut();
        Tx_ready = 1'b1;
        Enable   = 1'b1;
        for (int i = 0; i < NPAIRS; i++) Counts[i] = 4'($urandom);
        for (int i = 0; i < 2 * WINDOW && !(exp_q.size() != 0 && pos >= 3); i++) tick();
        chk("mid_valid", Tx_valid, 1);
        #2 Rst_n = 1'b0;
        #1 chk("mid_rst_drop", Tx_valid, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
        repeat (WINDOW + 12) tick();
        chk("mid_len", got_q.size(), 9);
        if (got_q.size() >= 9) begin
            chk("mid_hdr", got_q[0], 8'hA5);
            chk("mid_seq", got_q[1], 8'h00);
        end

        // Enable gating and seq wrap
        Enable = 1'b0;
        vcount = 0;
        repeat (100) begin
            tick();
            if (Tx_valid) vcount++;
        end
        chk("en_off_quiet", vcount, 0);
        Enable = 1'b1;
        repeat (257 * WINDOW) tick();
        found = 0;
        for (int i = 1; i < seq_log.size(); i++) begin
            if (seq_log[i-1] == 8'hFF && seq_log[i] == 8'h00) found = 1;
        end
        chk("seq_wrap", found, 1);
        chk("wrap_missed", Missed, 0);
        chk("wrap_overrun", Overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
